sd_block_reader: RTL and testbench

SD_BLOCK_READER -- requirements
Module: sd_block_reader

---
 rtl/sd_block_reader.sv | 175 +++++++++++++++++
 tb/tb_sd_block_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_reader.sv
// SPI-mode SD single-block reader: issues CMD17, waits for R1 and the data
// start token, streams the 512-byte payload out one byte at a time.
module sd_block_reader #(
    parameter int RESP_TIMEOUT  = 64,
    parameter int TOKEN_TIMEOUT = 65535
) (
    input  logic        sd_clk,
    input  logic        reset,
    input  logic        initialized,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic        sdDataBack,
    output logic        sdCs,
    output logic        sd_Data_IR,
    output logic        rd_busy,
    output logic        rd_done,
    output logic        rd_err,
    output logic [7:0]  data_out,
    output logic        data_valid
);

    typedef enum logic [3:0] {
        IDLE, DUMMY, CMD, RESP_WAIT, RESP, TOKEN_WAIT, DATA, CRC, TRAIL, DONE
    } state_t;

    localparam int TMO_MAX = (RESP_TIMEOUT > TOKEN_TIMEOUT) ? RESP_TIMEOUT : TOKEN_TIMEOUT;
    localparam int TMO_W   = $clog2(TMO_MAX + 1);
    localparam int CW      = (TMO_W > 12) ? TMO_W : 12;
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [47:0]    cmd_q, cmd_d;
    logic [7:0]     shift_q, shift_d;
    logic           err_q, err_d;
    logic [7:0]     data_out_q, data_out_d;
    logic           data_valid_q, data_valid_d;

    always_ff @(posedge sd_clk) begin
        // NOTE: reset is tested inside the clocked block, so it only takes effect on an sd_clk edge.
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmd_q        <= '0;
            shift_q      <= '0;
            err_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop load from pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            shift_q      <= shift_d;
            err_q        <= err_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        // NOTE: every _d starts from its hold value, so no branch can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        shift_d      = shift_q;
        err_d        = err_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_req && initialized) begin
                    cmd_d   = {8'h51, rd_addr, 8'hFF};
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DUMMY;
                end
            end
            DUMMY: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == CW'(7)) begin
                    cnt_d   = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                cmd_d = {cmd_q[46:0], 1'b1};
                cnt_d = cnt_q + ONE;
                if (cnt_q == CW'(47)) begin
                    cnt_d   = '0;
                    state_d = RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                cnt_d = cnt_q + ONE;
                if (!sdDataBack) begin
                    shift_d = 8'h00;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CW'(RESP_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = TRAIL;
                end
            end
            RESP: begin
                shift_d = {shift_q[6:0], sdDataBack};
                cnt_d   = cnt_q + ONE;
                if (cnt_q == CW'(6)) begin
                    cnt_d   = '0;
                    err_d   = (shift_d != 8'h00);
                    state_d = (shift_d != 8'h00) ? TRAIL : TOKEN_WAIT;
                    shift_d = 8'hFF;
                end
            end
            TOKEN_WAIT: begin
                // Tokens are only decoded once a full byte has been shifted in.
                shift_d = {shift_q[6:0], sdDataBack};
                cnt_d   = cnt_q + ONE;
                if (cnt_q >= CW'(7) && shift_d == 8'hFE) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else if (cnt_q >= CW'(7) && shift_d[7:4] == 4'h0 && shift_d[3:0] != 4'h0) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = TRAIL;
                end else if (cnt_q == CW'(TOKEN_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = TRAIL;
                end
            end
            DATA: begin
                shift_d = {shift_q[6:0], sdDataBack};
                cnt_d   = cnt_q + ONE;
                if (cnt_q[2:0] == 3'd7) begin
                    data_out_d   = shift_d;
                    data_valid_d = 1'b1;
                end
                if (cnt_q == CW'(4095)) begin
                    cnt_d   = '0;
                    state_d = CRC;
                end
            end
            CRC: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == CW'(15)) begin
                    cnt_d   = '0;
                    state_d = TRAIL;
                end
            end
            TRAIL: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == CW'(7)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_busy    = (state_q != IDLE);
    assign sdCs       = (state_q == IDLE) || (state_q == TRAIL) || (state_q == DONE);
    assign sd_Data_IR = (state_q == CMD) ? cmd_q[47] : 1'b1;
    assign rd_done    = (state_q == DONE);
    assign rd_err     = (state_q == DONE) && err_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader: nominal read, R1 error, response
// timeout, data error token, request gating and reset during the payload.
module tb_sd_block_reader;

    logic        sd_clk = 1'b0;
    logic        reset;
    logic        initialized;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        sdDataBack;
    logic        sdCs;
    logic        sd_Data_IR;
    logic        rd_busy;
    logic        rd_done;
    logic        rd_err;
    logic [7:0]  data_out;
    logic        data_valid;

    sd_block_reader #(.RESP_TIMEOUT(64), .TOKEN_TIMEOUT(65535)) dut (
        .sd_clk     (sd_clk),
        .reset      (reset),
        .initialized(initialized),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .sdDataBack (sdDataBack),
        .sdCs       (sdCs),
        .sd_Data_IR (sd_Data_IR),
        .rd_busy    (rd_busy),
        .rd_done    (rd_done),
        .rd_err     (rd_err),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 sd_clk = ~sd_clk;

    int tests = 0;
    int fails = 0;

    // Passive monitor, sampled on the falling edge.
    int         cyc = 0;
    int         busy_start = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         trail_len = 0;
    int         cs_run = 0;
    int         err_stray = 0;
    logic       done_err = 1'b0;
    logic       busy_prev = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge sd_clk) begin
        cyc++;
        if (rd_busy === 1'b1 && busy_prev !== 1'b1) busy_start = cyc;
        busy_prev = rd_busy;
        if (data_valid === 1'b1) rx_q.push_back(data_out);
        if (rd_done === 1'b1) begin
            done_cnt++;
            done_err  = rd_err;
            done_cyc  = cyc;
            trail_len = cs_run;
        end
        if (rd_busy === 1'b1 && sdCs === 1'b1) cs_run++;
        else cs_run = 0;
        if (rd_err === 1'b1 && rd_done !== 1'b1) err_stray++;
    end

    int dv_base = 0;
    int done_base = 0;
    logic [47:0] frame;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        @(negedge sd_clk);
        sdDataBack = b;
    endtask

    task automatic byte_out(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
    endtask

    // Called at a falling edge while idle; returns at the falling edge of the last CMD cycle.
    task automatic start_req(input logic [31:0] addr, input bit disturb, output logic [47:0] frm);
        int dummy_bad = 0;
        int cs_bad = 0;
        dv_base   = rx_q.size();
        done_base = done_cnt;
        rd_addr = addr;
        rd_req  = 1'b1;
        @(negedge sd_clk);
        rd_req = 1'b0;
        check("busy_after_req", rd_busy, 1);
        check("cs_after_req", sdCs, 0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge sd_clk);
            if (sd_Data_IR !== 1'b1 || sdCs !== 1'b0) dummy_bad++;
            if (disturb && i == 2) begin
                rd_req  = 1'b1;
                rd_addr = 32'hDEADBEEF;
            end
            if (disturb && i == 3) begin
                rd_req      = 1'b0;
                initialized = 1'b0;
            end
        end
        check("dummy_mosi_cs", dummy_bad, 0);
        frm = '0;
        for (int i = 0; i < 48; i++) begin
            @(negedge sd_clk);
            frm = {frm[46:0], sd_Data_IR};
            if (sdCs !== 1'b0) cs_bad++;
        end
        check("cmd_cs_low", cs_bad, 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge sd_clk);
        sdDataBack = 1'b1;
        #1;
        while (done_cnt == done_base && n < budget) begin
            @(negedge sd_clk);
            #1;
            n++;
        end
        check("done_seen", done_cnt - done_base, 1);
        @(negedge sd_clk);
        check("idle_after_done", {rd_busy, rd_done, rd_err, sdCs}, 4'b0001);
    endtask

    task automatic check_txn(input string tag, input int exp_err, input int exp_dv, input int exp_len);
        check({tag, "_rd_err"}, done_err, exp_err);
        check({tag, "_dv_count"}, rx_q.size() - dv_base, exp_dv);
        check({tag, "_trail_len"}, trail_len, 8);
        check({tag, "_latency"}, done_cyc - busy_start, exp_len);
    endtask

    task automatic card_nominal_prefix();
        bit_out(1'b1);
        bit_out(1'b1);
        byte_out(8'h00);
        for (int i = 0; i < 20; i++) bit_out(1'b1);
        byte_out(8'hFE);
    endtask

    task automatic check_payload();
        logic [7:0] e;
        for (int i = 0; i < 512; i++) begin
            e = 8'(i);
            check("payload_byte", rx_q[dv_base + i], e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        initialized = 1'b1;
        rd_req      = 1'b0;
        rd_addr     = '0;
        sdDataBack  = 1'b1;
        repeat (3) @(negedge sd_clk);
        check("reset_outputs", {sdCs, sd_Data_IR, rd_busy, rd_done, rd_err, data_valid}, 6'b110000);
        check("reset_data_out", data_out, 8'h00);
        reset = 1'b0;
        @(negedge sd_clk);

        // Nominal read of block 5.
        start_req(32'h0000_0005, 1'b0, frame);
        check("nom_frame", frame, {8'h51, 32'h0000_0005, 8'hFF});
        card_nominal_prefix();
        for (int i = 0; i < 512; i++) byte_out(8'(i));
        byte_out(8'hAB);
        byte_out(8'hCD);
        wait_done(50);
        check_txn("nom", 0, 512, 4214);
        check_payload();

        // R1 = 0x04.
        start_req(32'h0000_0010, 1'b0, frame);
        bit_out(1'b1);
        bit_out(1'b1);
        byte_out(8'h04);
        wait_done(50);
        check_txn("r1err", 1, 0, 74);

        // No response at all.
        start_req(32'h0000_0020, 1'b0, frame);
        wait_done(200);
        check_txn("resp_tmo", 1, 0, 128);

        // Data error token 0x08 right after R1.
        start_req(32'h0000_0030, 1'b0, frame);
        bit_out(1'b1);
        bit_out(1'b1);
        byte_out(8'h00);
        byte_out(8'h08);
        wait_done(50);
        check_txn("tok_err", 1, 0, 82);

        // Request gating.
        initialized = 1'b0;
        rd_req      = 1'b1;
        rd_addr     = 32'h0BAD_0001;
        @(negedge sd_clk);
        rd_req = 1'b0;
        @(negedge sd_clk);
        check("gate_uninit", {rd_busy, sdCs}, 2'b01);
        initialized = 1'b1;
        @(negedge sd_clk);
        initialized = 1'b0;
        rd_req      = 1'b1;
        @(negedge sd_clk);
        rd_req = 1'b0;
        check("gate_init_fall", {rd_busy, sdCs}, 2'b01);
        initialized = 1'b1;
        @(negedge sd_clk);
        start_req(32'h1234_5678, 1'b1, frame);
        check("busy_req_frame", frame, {8'h51, 32'h1234_5678, 8'hFF});
        bit_out(1'b1);
        bit_out(1'b1);
        byte_out(8'h04);
        wait_done(50);
        check_txn("gate", 1, 0, 74);
        initialized = 1'b1;
        repeat (4) @(negedge sd_clk);
        check("no_queued_req", {rd_busy, sdCs}, 2'b01);

        // Reset after byte 100 of the payload, then a clean read.
        start_req(32'h0000_0A00, 1'b0, frame);
        card_nominal_prefix();
        for (int i = 0; i < 100; i++) byte_out(8'(i));
        @(negedge sd_clk);
        reset      = 1'b1;
        sdDataBack = 1'b1;
        @(negedge sd_clk);
        #1;
        check("rst_mid_outputs", {sdCs, rd_busy, rd_done, data_valid}, 4'b1000);
        check("rst_mid_bytes", rx_q.size() - dv_base, 100);
        check("rst_mid_last_byte", rx_q[rx_q.size() - 1], 8'd99);
        reset = 1'b0;
        repeat (4) @(negedge sd_clk);
        check("rst_mid_no_done", done_cnt - done_base, 0);
        check("rst_mid_idle", rd_busy, 0);
        start_req(32'h0000_0A01, 1'b0, frame);
        check("recov_frame", frame, {8'h51, 32'h0000_0A01, 8'hFF});
        card_nominal_prefix();
        for (int i = 0; i < 512; i++) byte_out(8'(i));
        byte_out(8'h12);
        byte_out(8'h34);
        wait_done(50);
        check_txn("recov", 0, 512, 4214);
        check_payload();

        check("rd_err_outside_done", err_stray, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
